// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: 64 sets of one 64-bit word,
// external metadata/data RAMs with registered reads, single memory-bus master.
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  input  logic        flush,
  output logic        meta_en,
  output logic        meta_wr,
  output logic        meta_flush,
  output logic [5:0]  meta_addr,
  output logic [22:0] meta_wtag,
  output logic        meta_wvalid,
  output logic        meta_wdirty,
  input  logic        meta_valid,
  input  logic        meta_dirty,
  input  logic [22:0] meta_tag,
  output logic        data_en,
  output logic        data_wr,
  output logic [5:0]  data_addr,
  output logic [63:0] data_wdata,
  output logic [7:0]  data_wmask,
  input  logic [63:0] data_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wr,
  output logic [31:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_RESP, RF_REQ, RF_RESP} state_t;

  state_t      state;
  logic        flush_pend;
  logic        r_wr;
  logic [28:0] r_line;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic [22:0] v_tag;
  logic [63:0] v_data;

  logic [22:0] r_tag;
  logic [5:0]  r_idx;
  logic        hit, accept, do_flush;
  logic [63:0] merged;
  logic        unused_ok;

  assign r_tag     = r_line[28:6];
  assign r_idx     = r_line[5:0];
  assign unused_ok = ^req_addr[2:0];
  assign dbg_state = state;

  // Outputs are gated by rst_n so everything reads 0 while reset is held.
  assign do_flush  = rst_n && (state == IDLE) && (flush || flush_pend);
  assign req_ready = rst_n && (state == IDLE) && !flush && !flush_pend;
  assign accept    = req_ready && req_valid;
  assign hit       = meta_valid && (meta_tag == r_tag);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = (r_wr && r_wmask[i]) ? r_wdata[8*i +: 8] : mem_resp_rdata[8*i +: 8];
    end
  end

  always_comb begin
    meta_en = 1'b0; meta_wr = 1'b0; meta_addr = '0; meta_wtag = '0;
    meta_wvalid = 1'b0; meta_wdirty = 1'b0; meta_flush = do_flush;
    data_en = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wmask = '0;
    resp_valid = 1'b0; resp_rdata = '0;
    mem_req_valid = 1'b0; mem_req_wr = 1'b0; mem_req_addr = '0; mem_req_wdata = '0;
    case (state)
      IDLE: if (accept) begin
        meta_en   = 1'b1;
        data_en   = 1'b1;
        meta_addr = req_addr[8:3];
        data_addr = req_addr[8:3];
      end
      LOOKUP: if (hit) begin
        resp_valid = 1'b1;
        resp_rdata = data_rdata;
        if (r_wr) begin
          meta_en = 1'b1; meta_wr = 1'b1; meta_addr = r_idx; meta_wtag = r_tag;
          meta_wvalid = 1'b1; meta_wdirty = 1'b1;
          data_en = 1'b1; data_wr = 1'b1; data_addr = r_idx;
          data_wdata = r_wdata; data_wmask = r_wmask;
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = {v_tag, r_idx, 3'b000};
        mem_req_wdata = v_data;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_tag, r_idx, 3'b000};
      end
      RF_RESP: if (mem_resp_valid) begin
        meta_en = 1'b1; meta_wr = 1'b1; meta_addr = r_idx; meta_wtag = r_tag;
        meta_wvalid = 1'b1; meta_wdirty = r_wr;
        data_en = 1'b1; data_wr = 1'b1; data_addr = r_idx;
        data_wdata = merged; data_wmask = 8'hFF;
        resp_valid = 1'b1;
        resp_rdata = mem_resp_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      r_wr       <= 1'b0;
      r_line     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      v_tag      <= '0;
      v_data     <= '0;
    end else begin
      // A flush seen mid-operation waits until the controller is back in IDLE.
      if (state != IDLE && flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (do_flush) begin
            flush_pend <= 1'b0;
          end else if (accept) begin
            r_wr    <= req_wr;
            r_line  <= req_addr[31:3];
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else if (meta_valid && meta_dirty) begin
            v_tag  <= meta_tag;
            v_data <= data_rdata;
            state  <= WB_REQ;
          end else begin
            state <= RF_REQ;
          end
        end
        WB_REQ:  if (mem_req_ready) state <= WB_RESP;
        WB_RESP: if (mem_resp_valid) state <= RF_REQ;
        RF_REQ:  if (mem_req_ready) state <= RF_RESP;
        RF_RESP: if (mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
